// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory, shared-ALU multicycle RISC-V style datapath.
// Outputs are decoded from the current state (plus Zero / mem_ready), never registered.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               retire_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_BEQ      = STATE_W'(9),
    S_ILLEGAL  = STATE_W'(10)
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    retire_o  = 1'b0;
    illegal_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire_o  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire_o = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        PCWrite  = Zero;
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      // Absorbing: only reset leaves, so the flag stays sticky.
      S_ILLEGAL: illegal_o = 1'b1;
      default:   state_d   = S_FETCH;
    endcase
    // Async reset already forces FETCH; also mask its strobes while rst is held low.
    if (!rst) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retire_o = 1'b0;
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    if (Op == OP_SW)       ImmSrc = 2'b01;
    else if (Op == OP_BEQ) ImmSrc = 2'b10;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class and reset cases.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       retire_o, illegal_o;
  logic [3:0] state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .retire_o(retire_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  // Tasks are entered during the clock-low phase with the DUT in FETCH;
  // inputs change there and outputs are sampled 1 time unit later.
  task automatic test_reset();
    rst = 1'b0; Op = 7'd0; Zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_cmp++; if ({PCWrite, IRWrite, RegWrite, MemWrite, retire_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=00000", {PCWrite, IRWrite, RegWrite, MemWrite, retire_o}); end
    n_cmp++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (state_o !== 4'd0 || mem_req !== 1'b1 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_wait cyc=%0d got state=%0d req=%b pcw=%b irw=%b exp 0 1 0 0",
                           i, state_o, mem_req, PCWrite, IRWrite); end
      n_cmp++; if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 || AdrSrc !== 1'b0) begin
        n_fail++; $display("FAIL fetch_muxes got srcb=%b res=%b adr=%b exp 10 10 0", ALUSrcB, ResultSrc, AdrSrc); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      n_fail++; $display("FAIL fetch_ready_strobes got pcw=%b irw=%b exp 1 1", PCWrite, IRWrite); end
  endtask

  task automatic test_lw();
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    int ret = 0;
    Op = 7'b0000011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (state_o !== es[i]) begin n_fail++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state_o, es[i]); end
      n_cmp++; if (RegWrite !== (es[i] == 4'd4)) begin n_fail++; $display("FAIL lw_regwrite cyc=%0d got=%b", i, RegWrite); end
      if (es[i] == 4'd4) begin
        n_cmp++; if (ResultSrc !== 2'b01) begin n_fail++; $display("FAIL lw_resultsrc got=%b exp=01", ResultSrc); end
      end
      if (es[i] == 4'd3) begin
        n_cmp++; if (mem_req !== 1'b1 || AdrSrc !== 1'b1) begin
          n_fail++; $display("FAIL lw_memread got req=%b adr=%b exp 1 1", mem_req, AdrSrc); end
      end
      if (retire_o === 1'b1) ret++;
      if (i < 5) @(negedge clk);
    end
    n_cmp++; if (ret !== 1) begin n_fail++; $display("FAIL lw_retire_count got=%0d exp=1", ret); end
  endtask

  task automatic test_sw_wait();
    logic [3:0] es  [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic       rdy [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int mw = 0;
    Op = 7'b0100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      n_cmp++; if (state_o !== es[i]) begin n_fail++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, state_o, es[i]); end
      n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL sw_regwrite cyc=%0d got=%b exp=0", i, RegWrite); end
      n_cmp++; if (retire_o !== (i == 6)) begin n_fail++; $display("FAIL sw_retire cyc=%0d got=%b exp=%b", i, retire_o, i == 6); end
      if (MemWrite === 1'b1) mw++;
      if (i < 7) @(negedge clk);
    end
    n_cmp++; if (mw !== 4) begin n_fail++; $display("FAIL sw_memwrite_cycles got=%0d exp=4", mw); end
    n_cmp++; if (ImmSrc !== 2'b01) begin n_fail++; $display("FAIL sw_immsrc got=%b exp=01", ImmSrc); end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    Op = 7'b1100011; Zero = z; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (state_o !== es[i]) begin n_fail++; $display("FAIL beq_state z=%b cyc=%0d got=%0d exp=%0d", z, i, state_o, es[i]); end
      if (i == 1) begin
        n_cmp++; if (PCWrite !== 1'b0 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b01) begin
          n_fail++; $display("FAIL decode_outputs got pcw=%b a=%b b=%b exp 0 01 01", PCWrite, ALUSrcA, ALUSrcB); end
      end
      if (i == 2) begin
        n_cmp++; if (PCWrite !== z) begin n_fail++; $display("FAIL beq_pcwrite z=%b got=%b exp=%b", z, PCWrite, z); end
        n_cmp++; if (retire_o !== 1'b1 || ALUOp !== 2'b01) begin
          n_fail++; $display("FAIL beq_retire_aluop got ret=%b op=%b exp 1 01", retire_o, ALUOp); end
      end
      if (i < 3) @(negedge clk);
    end
    n_cmp++; if (ImmSrc !== 2'b10) begin n_fail++; $display("FAIL beq_immsrc got=%b exp=10", ImmSrc); end
    Zero = 1'b0;
  endtask

  task automatic test_alu(input logic [6:0] op, input logic [3:0] ex_state, input logic [1:0] ex_srcb);
    logic [3:0] es [5];
    es = '{4'd0, 4'd1, ex_state, 4'd7, 4'd0};
    Op = op; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (state_o !== es[i]) begin n_fail++; $display("FAIL alu_state op=%b cyc=%0d got=%0d exp=%0d", op, i, state_o, es[i]); end
      if (i == 2) begin
        n_cmp++; if (ALUSrcB !== ex_srcb || ALUOp !== 2'b10 || ALUSrcA !== 2'b10) begin
          n_fail++; $display("FAIL alu_exec op=%b got b=%b op=%b a=%b exp %b 10 10", op, ALUSrcB, ALUOp, ALUSrcA, ex_srcb); end
      end
      if (i == 3) begin
        n_cmp++; if (RegWrite !== 1'b1 || ResultSrc !== 2'b00 || retire_o !== 1'b1) begin
          n_fail++; $display("FAIL alu_wb op=%b got rw=%b res=%b ret=%b exp 1 00 1", op, RegWrite, ResultSrc, retire_o); end
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_illegal_and_abort();
    logic [3:0] es [3] = '{4'd0, 4'd1, 4'd10};
    logic [3:0] ls [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
    logic       lr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    Op = 7'b1101111; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (state_o !== es[i]) begin n_fail++; $display("FAIL illegal_entry cyc=%0d got=%0d exp=%0d", i, state_o, es[i]); end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      n_cmp++; if (state_o !== 4'd10 || illegal_o !== 1'b1 || mem_req !== 1'b0 || PCWrite !== 1'b0 || retire_o !== 1'b0) begin
        n_fail++; $display("FAIL illegal_hold cyc=%0d got state=%0d ill=%b req=%b pcw=%b ret=%b exp 10 1 0 0 0",
                           i, state_o, illegal_o, mem_req, PCWrite, retire_o); end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (state_o !== 4'd0 || illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL illegal_clear got state=%0d ill=%b exp 0 0", state_o, illegal_o); end
    @(negedge clk);
    rst = 1'b1; Op = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = lr[i];
      #1;
      n_cmp++; if (state_o !== ls[i]) begin n_fail++; $display("FAIL abort_lead cyc=%0d got=%0d exp=%0d", i, state_o, ls[i]); end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (state_o !== 4'd0 || mem_req !== 1'b0 || RegWrite !== 1'b0 || retire_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_in_reset got state=%0d req=%b rw=%b ret=%b exp 0 0 0 0", state_o, mem_req, RegWrite, retire_o); end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    n_cmp++; if (state_o !== 4'd0 || mem_req !== 1'b1 || IRWrite !== 1'b0 || RegWrite !== 1'b0 || AdrSrc !== 1'b0) begin
      n_fail++; $display("FAIL abort_release got state=%0d req=%b irw=%b rw=%b adr=%b exp 0 1 0 0 0",
                         state_o, mem_req, IRWrite, RegWrite, AdrSrc); end
    @(negedge clk);
    #1;
    n_cmp++; if (state_o !== 4'd0) begin n_fail++; $display("FAIL abort_stays_fetch got=%0d exp=0", state_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_alu(7'b0110011, 4'd6, 2'b00);
    test_alu(7'b0010011, 4'd8, 2'b01);
    test_illegal_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
